// File: rtl/zap_tlb_pkg.sv
// Shared types and helpers for the ZAP unified fully-associative TLB.
package zap_tlb_pkg;

  // Page size held per entry; the encoding is the one the page walker produces.
  typedef enum logic [1:0] {
    SZ_SEC = 2'b00,  // 1 MB section,  tag VA[31:20]
    SZ_LPG = 2'b01,  // 64 KB large,   tag VA[31:16]
    SZ_SPG = 2'b10,  // 4 KB small,    tag VA[31:12]
    SZ_FPG = 2'b11   // 1 KB tiny,     tag VA[31:10]
  } tlb_size_e;

  // Stored tag is always VA[31:10]; the mask trims it down to the page size.
  localparam int ZAP_TLB_TAG_WDT = 22;

  function automatic logic [ZAP_TLB_TAG_WDT-1:0] tlb_mask(tlb_size_e size);
    case (size)
      SZ_SEC:  return 22'h3F_FC00;
      SZ_LPG:  return 22'h3F_FFC0;
      SZ_SPG:  return 22'h3F_FFFC;
      default: return 22'h3F_FFFF;
    endcase
  endfunction

  // True when two tags agree on every bit that matters for the given size.
  function automatic logic tlb_match(logic [ZAP_TLB_TAG_WDT-1:0] tag_a,
                                     logic [ZAP_TLB_TAG_WDT-1:0] tag_b,
                                     tlb_size_e                   size);
    return ((tag_a ^ tag_b) & tlb_mask(size)) == '0;
  endfunction

endpackage

// File: rtl/zap_plru_tree.sv
// Tree pseudo-LRU state for a power-of-two set of ways.
// Node n (heap numbering, root = 1) has children 2n and 2n+1; its bit
// selects the child the victim walk descends into (0 = lower half).
module zap_plru_tree #(
  parameter int ENTRIES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clear,
  input  logic                       i_touch_valid,
  input  logic [$clog2(ENTRIES)-1:0] i_touch_idx,
  output logic [$clog2(ENTRIES)-1:0] o_victim
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:1] tree_q, tree_d;
  logic [IDX_W-1:0]   victim;

  // Heap index of the ancestor of leaf 'leaf' sitting 'depth' levels below the root.
  function automatic logic [IDX_W-1:0] node_at(logic [IDX_W-1:0] leaf, int depth);
    return IDX_W'((ENTRIES + int'(leaf)) >> (IDX_W - depth));
  endfunction

  // Walk from the root following the node bits, building the victim MSB first.
  // NOTE: every variable assigned in an always_comb gets a value before any
  // branch, otherwise a latch is inferred to hold the old value.
  always_comb begin
    victim = '0;
    for (int l = 0; l < IDX_W; l++) begin
      victim[IDX_W-1-l] = tree_q[node_at(victim, l)];
    end
  end

  assign o_victim = victim;

  // Clear wins; a touch flips every node on the path to point at the other half.
  always_comb begin
    tree_d = tree_q;
    if (i_clear) begin
      tree_d = '0;
    end else if (i_touch_valid) begin
      for (int l = 0; l < IDX_W; l++) begin
        tree_d[node_at(i_touch_idx, l)] = ~i_touch_idx[IDX_W-1-l];
      end
    end
  end

  // PLRU node register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tree_q <= '0;
    else            tree_q <= tree_d;
  end

endmodule

// File: rtl/zap_tlb_assoc.sv
// Unified fully-associative TLB entry store: sections, large, small and tiny
// pages share one array, matched by per-entry masked tag compare.
module zap_tlb_assoc
  import zap_tlb_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int DATA_WDT = 32,
  parameter int CNT_WDT  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_lkp_valid,
  input  logic [31:0]         i_lkp_va,
  output logic                o_lkp_valid,
  output logic                o_lkp_hit,
  output logic [1:0]          o_lkp_size,
  output logic [DATA_WDT-1:0] o_lkp_data,
  output logic                o_lkp_multi,
  input  logic                i_fill_valid,
  input  logic [31:0]         i_fill_va,
  input  logic [1:0]          i_fill_size,
  input  logic [DATA_WDT-1:0] i_fill_data,
  input  logic                i_inv_all,
  input  logic                i_inv_va_valid,
  input  logic [31:0]         i_inv_va,
  output logic [CNT_WDT-1:0]  o_hit_cnt,
  output logic [CNT_WDT-1:0]  o_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic                       valid;
    logic [ZAP_TLB_TAG_WDT-1:0] tag;
    tlb_size_e                  size;
    logic [DATA_WDT-1:0]        data;
  } entry_t;

  // Valid bits carry reset; tag/size/payload are plain storage.
  logic [ENTRIES-1:0]         valid_q, valid_d;
  logic [ZAP_TLB_TAG_WDT-1:0] tag_q  [ENTRIES];
  tlb_size_e                  size_q [ENTRIES];
  logic [DATA_WDT-1:0]        data_q [ENTRIES];
  entry_t                     ent    [ENTRIES];

  logic                       lkp_valid_q, lkp_hit_q, lkp_multi_q;
  tlb_size_e                  lkp_size_q;
  logic [DATA_WDT-1:0]        lkp_data_q;
  logic [CNT_WDT-1:0]         hit_cnt_q, miss_cnt_q;

  logic [ZAP_TLB_TAG_WDT-1:0] lkp_tag, fill_tag, inv_tag;
  tlb_size_e                  fill_size;
  logic [ENTRIES-1:0]         lkp_match, fill_match, inv_match;
  logic [IDX_W-1:0]           lkp_idx, dup_idx, free_idx, fill_idx, plru_victim;
  logic                       inv_any, fill_do, lkp_hit, lkp_multi;
  logic                       touch_valid;
  logic [IDX_W-1:0]           touch_idx;
  logic                       unused_va_offset;

  assign lkp_tag   = i_lkp_va[31:10];
  assign fill_tag  = i_fill_va[31:10];
  assign inv_tag   = i_inv_va[31:10];
  assign fill_size = tlb_size_e'(i_fill_size);

  // The page-offset bits never take part in any compare.
  assign unused_va_offset = ^{i_lkp_va[9:0], i_fill_va[9:0], i_inv_va[9:0]};

  // Structured view of each entry for the compare logic.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent[i] = '{valid: valid_q[i], tag: tag_q[i], size: size_q[i], data: data_q[i]};
    end
  end

  // Per-entry compares: lookup and invalidate use the entry's own size; a fill
  // only aliases an entry of the very same size (no duplicates).
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      lkp_match[i]  = ent[i].valid & tlb_match(ent[i].tag, lkp_tag, ent[i].size);
      inv_match[i]  = ent[i].valid & tlb_match(ent[i].tag, inv_tag, ent[i].size);
      fill_match[i] = ent[i].valid & (ent[i].size == fill_size) &
                      tlb_match(ent[i].tag, fill_tag, fill_size);
    end
  end

  // Lowest-index priority pick for lookup match, duplicate fill and free slot.
  always_comb begin
    lkp_idx  = '0;
    dup_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lkp_match[i])  lkp_idx  = IDX_W'(i);
      if (fill_match[i]) dup_idx  = IDX_W'(i);
      if (!valid_q[i])   free_idx = IDX_W'(i);
    end
  end

  // Any invalidate in the cycle hides the array from the lookup and kills the fill.
  assign inv_any   = i_inv_all | i_inv_va_valid;
  assign lkp_hit   = (|lkp_match) & ~inv_any;
  assign lkp_multi = ((lkp_match & (lkp_match - 1'b1)) != '0) & ~inv_any;
  assign fill_do   = i_fill_valid & ~inv_any;
  assign fill_idx  = (|fill_match) ? dup_idx  :
                     (~&valid_q)   ? free_idx : plru_victim;

  // Fill touch has priority; a lookup only touches when no fill shares its cycle.
  assign touch_valid = fill_do | (i_lkp_valid & lkp_hit & ~i_fill_valid);
  assign touch_idx   = fill_do ? fill_idx : lkp_idx;

  zap_plru_tree #(
    .ENTRIES(ENTRIES)
  ) u_plru (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_inv_all),
    .i_touch_valid(touch_valid),
    .i_touch_idx  (touch_idx),
    .o_victim     (plru_victim)
  );

  // Valid-bit next state: invalidate-all, then invalidate-by-MVA, then fill.
  always_comb begin
    valid_d = valid_q;
    if (i_inv_all) begin
      valid_d = '0;
    end else if (i_inv_va_valid) begin
      valid_d = valid_q & ~inv_match;
    end else if (fill_do) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  // Valid-bit register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) valid_q <= '0;
    else            valid_q <= valid_d;
  end

  // Entry payload write on an accepted fill.
  // NOTE: the storage array has no reset; an entry's contents are only ever
  // observed through its valid bit, so clearing the payload would be wasted logic.
  always_ff @(posedge i_clk) begin
    if (fill_do) begin
      tag_q[fill_idx]  <= fill_tag;
      size_q[fill_idx] <= fill_size;
      data_q[fill_idx] <= i_fill_data;
    end
  end

  // Registered lookup result; fields other than valid hold between requests.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lkp_valid_q <= 1'b0;
      lkp_hit_q   <= 1'b0;
      lkp_multi_q <= 1'b0;
      lkp_size_q  <= SZ_SEC;
      lkp_data_q  <= '0;
    end else begin
      lkp_valid_q <= i_lkp_valid;
      if (i_lkp_valid) begin
        lkp_hit_q   <= lkp_hit;
        lkp_multi_q <= lkp_multi;
        lkp_size_q  <= lkp_hit ? ent[lkp_idx].size : SZ_SEC;
        lkp_data_q  <= lkp_hit ? ent[lkp_idx].data : '0;
      end
    end
  end

  // Saturating hit/miss statistics, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (i_lkp_valid) begin
      if (lkp_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WDT'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WDT'(1);
      end
    end
  end

  assign o_lkp_valid = lkp_valid_q;
  assign o_lkp_hit   = lkp_hit_q;
  assign o_lkp_multi = lkp_multi_q;
  assign o_lkp_size  = lkp_size_q;
  assign o_lkp_data  = lkp_data_q;
  assign o_hit_cnt   = hit_cnt_q;
  assign o_miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_zap_tlb_assoc.sv
// Directed bench for zap_tlb_assoc with a reference model built from
// per-entry VA ranges and touch timestamps.
module tb_zap_tlb_assoc;

  localparam int NE  = 4;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          lkp_valid, fill_valid, inv_all, inv_va_valid;
  logic [31:0]   lkp_va, fill_va, inv_va;
  logic [1:0]    fill_size;
  logic [DW-1:0] fill_data;
  logic          o_lkp_valid, o_lkp_hit, o_lkp_multi;
  logic [1:0]    o_lkp_size;
  logic [DW-1:0] o_lkp_data;
  logic [CW-1:0] o_hit_cnt, o_miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  zap_tlb_assoc #(.ENTRIES(NE), .DATA_WDT(DW), .CNT_WDT(CW)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_lkp_valid   (lkp_valid),
    .i_lkp_va      (lkp_va),
    .o_lkp_valid   (o_lkp_valid),
    .o_lkp_hit     (o_lkp_hit),
    .o_lkp_size    (o_lkp_size),
    .o_lkp_data    (o_lkp_data),
    .o_lkp_multi   (o_lkp_multi),
    .i_fill_valid  (fill_valid),
    .i_fill_va     (fill_va),
    .i_fill_size   (fill_size),
    .i_fill_data   (fill_data),
    .i_inv_all     (inv_all),
    .i_inv_va_valid(inv_va_valid),
    .i_inv_va      (inv_va),
    .o_hit_cnt     (o_hit_cnt),
    .o_miss_cnt    (o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NE];
  logic [31:0] m_va    [NE];
  logic [1:0]  m_size  [NE];
  logic [31:0] m_data  [NE];
  int          m_stamp [NE];
  int          m_time;

  bit          exp_valid, exp_hit, exp_multi;
  logic [1:0]  exp_size;
  logic [31:0] exp_data;
  int          exp_hit_cnt, exp_miss_cnt;

  // Low address bit where a page of this size begins.
  function automatic int page_shift(logic [1:0] s);
    case (s)
      2'd0:    return 20;
      2'd1:    return 16;
      2'd2:    return 12;
      default: return 10;
    endcase
  endfunction

  // Does valid entry i map the page containing va?
  function automatic bit covers(int i, logic [31:0] va);
    int sh;
    sh = page_shift(m_size[i]);
    return m_valid[i] && ((m_va[i] >> sh) == (va >> sh));
  endfunction

  // The victim lies in whichever half has gone longer without a touch;
  // untouched halves tie and the lower one is taken.
  function automatic int model_victim();
    int lo, n, half, ml, mr;
    lo = 0;
    n  = NE;
    while (n > 1) begin
      half = n / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < half; i++) begin
        if (m_stamp[lo + i] > ml)        ml = m_stamp[lo + i];
        if (m_stamp[lo + half + i] > mr) mr = m_stamp[lo + half + i];
      end
      if (ml > mr) lo = lo + half;
      n = half;
    end
    return lo;
  endfunction

  task automatic touch(input int i);
    m_time++;
    m_stamp[i] = m_time;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0;
      m_stamp[i] = 0;
    end
    m_time = 0;
    exp_valid = 0; exp_hit = 0; exp_multi = 0; exp_size = 0; exp_data = 0;
    exp_hit_cnt = 0; exp_miss_cnt = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs driven this cycle.
  task automatic model_step();
    int  first, cnt, tgt;
    bit  inv, hit;
    inv = inv_all || inv_va_valid;
    hit = 0;
    first = -1;
    cnt = 0;
    if (lkp_valid) begin
      for (int i = 0; i < NE; i++) begin
        if (covers(i, lkp_va)) begin
          cnt++;
          if (first < 0) first = i;
        end
      end
      hit = !inv && (cnt > 0);
      exp_valid = 1;
      exp_hit   = hit;
      exp_multi = !inv && (cnt > 1);
      exp_data  = hit ? m_data[first] : 32'h0;
      if (hit) begin
        exp_size = m_size[first];
        if (exp_hit_cnt < CNT_MAX) exp_hit_cnt++;
      end else begin
        if (exp_miss_cnt < CNT_MAX) exp_miss_cnt++;
      end
    end else begin
      exp_valid = 0;
    end

    if (inv_all) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] = 0;
        m_stamp[i] = 0;
      end
      m_time = 0;
    end else if (inv_va_valid) begin
      for (int i = 0; i < NE; i++) if (covers(i, inv_va)) m_valid[i] = 0;
    end else if (fill_valid) begin
      tgt = -1;
      for (int i = NE - 1; i >= 0; i--)
        if (m_size[i] == fill_size && covers(i, fill_va)) tgt = i;
      if (tgt < 0)
        for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) tgt = i;
      if (tgt < 0) tgt = model_victim();
      m_valid[tgt] = 1;
      m_va[tgt]    = fill_va;
      m_size[tgt]  = fill_size;
      m_data[tgt]  = fill_data;
      touch(tgt);
    end else if (hit) begin
      touch(first);
    end
  endtask

  // Continuous comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("lkp_valid", o_lkp_valid, exp_valid);
      check("lkp_hit",   o_lkp_hit,   exp_hit);
      check("lkp_multi", o_lkp_multi, exp_multi);
      check("lkp_data",  o_lkp_data,  exp_data);
      if (exp_hit) check("lkp_size", o_lkp_size, exp_size);
      check("hit_cnt",   o_hit_cnt,   exp_hit_cnt);
      check("miss_cnt",  o_miss_cnt,  exp_miss_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    lkp_valid = 0; fill_valid = 0; inv_all = 0; inv_va_valid = 0;
  endtask

  task automatic do_lookup(input logic [31:0] va);
    lkp_valid = 1;
    lkp_va    = va;
    cycle();
  endtask

  task automatic do_fill(input logic [31:0] va, input logic [1:0] sz, input logic [31:0] d);
    fill_valid = 1;
    fill_va    = va;
    fill_size  = sz;
    fill_data  = d;
    cycle();
  endtask

  initial begin
    rst_n = 0;
    lkp_valid = 0; fill_valid = 0; inv_all = 0; inv_va_valid = 0;
    lkp_va = 0; fill_va = 0; inv_va = 0; fill_size = 0; fill_data = 0;
    model_reset();
    cmp_en = 1;
    repeat (3) cycle();
    rst_n = 1;
    check("rst_valid",    o_lkp_valid, 0);
    check("rst_hit_cnt",  o_hit_cnt,   0);
    check("rst_miss_cnt", o_miss_cnt,  0);

    // First lookup after reset misses.
    do_lookup(32'h1234_5678);
    check("first_valid", o_lkp_valid, 1);
    check("first_hit",   o_lkp_hit,   0);
    check("first_miss",  o_miss_cnt,  1);
    check("first_hits",  o_hit_cnt,   0);
    cycle();
    check("idle_valid", o_lkp_valid, 0);

    // Section: whole 1 MB window hits, the next MB misses.
    do_fill(32'h0010_0000, 2'd0, 32'hA);
    do_lookup(32'h001F_FFFC);
    check("sec_hit",  o_lkp_hit,  1);
    check("sec_size", o_lkp_size, 0);
    check("sec_data", o_lkp_data, 32'hA);
    do_lookup(32'h0020_0000);
    check("sec_miss", o_lkp_hit, 0);
    check("sec_miss_data", o_lkp_data, 0);

    // Overlapping small page and section: multi-hit, lowest index wins.
    do_fill(32'h0000_3000, 2'd2, 32'hB);
    do_fill(32'h0000_0000, 2'd0, 32'hC);
    do_lookup(32'h0000_3004);
    check("multi_flag", o_lkp_multi, 1);
    check("multi_hit",  o_lkp_hit,   1);
    check("multi_data", o_lkp_data,  32'hB);
    inv_va_valid = 1;
    inv_va = 32'h0000_3000;
    cycle();
    do_lookup(32'h0000_3004);
    check("invva_miss", o_lkp_hit, 0);
    do_lookup(32'h0010_0000);
    check("invva_keep", o_lkp_hit, 1);

    // Invalidate-all together with a fill: the fill is dropped.
    inv_all = 1;
    fill_valid = 1; fill_va = 32'h0050_0000; fill_size = 2'd0; fill_data = 32'h77;
    cycle();
    do_lookup(32'h0050_0000);
    check("invall_fill_dropped", o_lkp_hit, 0);
    do_lookup(32'h001F_FFFC);
    check("invall_cleared", o_lkp_hit, 0);

    // Large and tiny page mask boundaries.
    do_fill(32'h4567_0000, 2'd1, 32'hD);
    do_lookup(32'h4567_FFFF);
    check("lpg_hit",  o_lkp_hit,  1);
    check("lpg_size", o_lkp_size, 1);
    do_lookup(32'h4568_0000);
    check("lpg_miss", o_lkp_hit, 0);
    do_fill(32'h7000_0400, 2'd3, 32'hE);
    do_lookup(32'h7000_07FC);
    check("fpg_hit",  o_lkp_hit,  1);
    check("fpg_size", o_lkp_size, 3);
    do_lookup(32'h7000_0000);
    check("fpg_miss", o_lkp_hit, 0);

    // Replacement: fill all four ways, touch 2,0,1, fifth fill evicts way 3.
    inv_all = 1;
    cycle();
    for (int i = 0; i < NE; i++) do_fill(32'h1000_0000 + 32'(i) * 32'h1000, 2'd2, 32'h100 + 32'(i));
    do_lookup(32'h1000_2000);
    do_lookup(32'h1000_0000);
    do_lookup(32'h1000_1000);
    do_fill(32'h2000_0000, 2'd2, 32'h200);
    do_lookup(32'h1000_3000);
    check("victim_evicted", o_lkp_hit, 0);
    do_lookup(32'h2000_0123);
    check("victim_new", o_lkp_data, 32'h200);
    // Refill of an existing page overwrites in place.
    do_fill(32'h1000_0000, 2'd2, 32'h300);
    do_lookup(32'h1000_0000);
    check("refill_data",  o_lkp_data,  32'h300);
    check("refill_multi", o_lkp_multi, 0);
    do_lookup(32'h1000_1000);
    check("refill_keep1", o_lkp_data, 32'h101);
    do_lookup(32'h1000_2000);
    check("refill_keep2", o_lkp_data, 32'h102);
    do_lookup(32'h2000_0000);
    check("refill_keep5", o_lkp_data, 32'h200);

    // Lookup alongside a fill of the same VA sees the old array.
    fill_valid = 1; fill_va = 32'h3000_0000; fill_size = 2'd0; fill_data = 32'h5;
    lkp_valid = 1; lkp_va = 32'h3000_0000;
    cycle();
    check("rbw_miss", o_lkp_hit, 0);
    do_lookup(32'h3000_0ABC);
    check("rbw_hit",  o_lkp_hit,  1);
    check("rbw_data", o_lkp_data, 32'h5);

    // Lookup alongside an unrelated invalidate is forced to miss.
    inv_va_valid = 1; inv_va = 32'h9000_0000;
    lkp_valid = 1; lkp_va = 32'h3000_0000;
    cycle();
    check("inv_lkp_miss", o_lkp_hit, 0);
    do_lookup(32'h3000_0000);
    check("inv_lkp_after", o_lkp_hit, 1);

    // Hit counter saturation.
    for (int i = 0; i < (1 << CW) + 5; i++) do_lookup(32'h3000_0000);
    check("hit_saturated", o_hit_cnt, 8'hFF);

    // Asynchronous reset while a lookup result is showing.
    lkp_valid = 1; lkp_va = 32'h3000_0000;
    @(posedge clk);
    model_step();
    #1;
    check("pre_rst_valid", o_lkp_valid, 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_rst_valid", o_lkp_valid, 0);
    check("async_rst_hits",  o_hit_cnt,   0);
    check("async_rst_miss",  o_miss_cnt,  0);
    repeat (2) cycle();
    rst_n = 1;
    do_lookup(32'h3000_0000);
    check("post_rst_miss", o_lkp_hit,  0);
    check("post_rst_cnt",  o_miss_cnt, 1);
    cycle();

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zap_tlb_assoc.md
Name: zap_tlb_assoc

Overview:
- Fully-associative, parametrised-depth unified TLB entry store for the ZAP MMU.
- Replaces the four fixed-size direct-mapped TLB memories with one array that holds section, large-page, small-page and tiny-page entries together.
- Page size is selected per entry by masked tag compare; victims are chosen by tree pseudo-LRU.
- Supports invalidate-all and invalidate-by-MVA, and keeps saturating hit/miss counters. Sits between the TLB check logic and the page-walk FSM.

Parameters:
- ENTRIES, 16, number of entries; power of two, 2..64.
- DATA_WDT, 32, payload width (PA base, AP, domain, C/B bits packed by the walker).
- CNT_WDT, 16, width of the hit and miss counters.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_lkp_valid  in  1  lookup request
- i_lkp_va  in  32  lookup virtual address
- o_lkp_valid  out  1  lookup result valid, one cycle after request
- o_lkp_hit  out  1  hit
- o_lkp_size  out  2  page size of hit entry
- o_lkp_data  out  DATA_WDT  payload of hit entry; 0 on miss
- o_lkp_multi  out  1  more than one entry matched (error)
- i_fill_valid  in  1  write a new entry
- i_fill_va  in  32  VA of fill
- i_fill_size  in  2  size encoding
- i_fill_data  in  DATA_WDT  payload
- i_inv_all  in  1  invalidate all entries
- i_inv_va_valid  in  1  invalidate by MVA
- i_inv_va  in  32  MVA to invalidate
- o_hit_cnt  out  CNT_WDT  saturating hit count
- o_miss_cnt  out  CNT_WDT  saturating miss count

Behaviour:
- Size encoding and tag bits compared: 00 section VA[31:20]; 01 large page VA[31:16]; 10 small page VA[31:12]; 11 tiny page VA[31:10].
- Each entry stores: valid, tag VA[31:10] (22b), size, payload. Compare = valid & (tag & mask(size)) == (VA[31:10] & mask(size)).
- Reset: all valid bits 0, PLRU bits 0, both counters 0, every o_lkp_* output 0.
- Lookup: match is combinational on the current array; the result is registered. o_lkp_valid is 1 in cycle N+1 for a request in cycle N, and 0 otherwise; all other o_lkp_* outputs hold their last value when o_lkp_valid=0.
- Multi-hit: on a multiple match, o_lkp_multi=1, o_lkp_hit=1, and data/size come from the lowest-index match.
- Hit: PLRU is updated to point away from the hit way, in the cycle of the request.
- Counters: in the request cycle, hit → o_hit_cnt+1 and miss → o_miss_cnt+1; each saturates at all-ones. Counters are cleared only by reset.
- Fill, single cycle, always accepted. Target entry selection:
  - existing entry with equal size and equal masked tag, if any (no duplicates);
  - else the lowest-index invalid entry;
  - else the PLRU victim.
  - The target becomes valid and PLRU is updated to point away from it.
- Invalidate-by-MVA: clears every valid entry whose masked tag matches i_inv_va under that entry's own size, so one MVA kills all sizes covering it.
- Invalidate-all: clears all valid bits and resets PLRU to 0 in one cycle.
- Same-cycle priority: inv_all > inv_va > fill > lookup PLRU touch.
  - Fill together with any invalidate is dropped.
  - Lookup together with any invalidate returns o_lkp_hit=0 and counts as a miss.
  - Lookup together with fill sees pre-fill state (read-before-write), and its PLRU touch is suppressed.
- Reset asserted mid-operation: state clears immediately; an in-flight lookup result is lost and o_lkp_valid=0.
- Width rule: VA[9:0] is ignored everywhere.

Decomposition:
- Package zap_tlb_pkg holds:
  - size enum (SEC/LPG/SPG/FPG);
  - ZAP_TLB_TAG_WDT=22;
  - function tlb_mask(size) returning the 22-bit compare mask;
  - entry struct {valid, tag, size, data}, parametrised via DATA_WDT in the module.
- Sub-module zap_plru_tree #(ENTRIES) holds the PLRU state. Inputs: touch valid/index, reset-to-zero. Output: victim index.

Test Plan:
- Reset, then lookup VA 0x1234_5678 → o_lkp_valid=1 next cycle, hit=0, miss_cnt=1, hit_cnt=0.
- Fill section VA 0x0010_0000, data 0xA; lookup 0x001F_FFFC → hit=1, size=00, data=0xA. Lookup 0x0020_0000 → miss.
- Fill small page 0x0000_3000 (data 0xB) and section 0x0000_0000 (data 0xC); lookup 0x0000_3004 → multi=1, data from lower index. Inv_va 0x0000_3000 → both entries cleared, next lookup misses.
- ENTRIES=4: fill 4 distinct pages, hit entries 0,1,2, fill a 5th → entry 3 replaced; re-fill an identical VA/size → same index overwritten, no new entry consumed.
- Fill and lookup of the same VA in the same cycle → miss; a lookup one cycle later → hit. inv_all asserted with a fill → all entries invalid and the fill dropped.
- Force 2^CNT_WDT+5 hits → o_hit_cnt saturates at all-ones. Assert i_reset_n=0 during a lookup → o_lkp_valid=0 and counters 0 asynchronously.
